// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU definitions: PC width, exception/interrupt cause codes and the
//   saved-exception-PC entry layout.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_EXT_INT = 4'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_SYSCALL = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_OVF     = 4'd4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [CAUSE_W-1:0] cause;
  } epc_entry_t;

endpackage

`default_nettype wire

// File: rtl/epc_stack.sv
// ----------------------------------------------------------------------------
// epc_stack
//   LIFO of exception return PCs with cause codes, one entry per nesting
//   level. push on interrupt/exception entry, pop on eret, push+pop together
//   is tail-chaining (top entry overwritten in place).
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     en              global enable; low holds every bit of state
//     push            save push_pc/push_cause as the new top
//     push_pc         resume PC
//     push_cause      cause code
//     pop             discard top entry
//     clr_err         clear sticky overflow/underflow
//     top_pc          PC of top entry (0 when empty)
//     top_cause       cause of top entry (0 when empty)
//     count           number of valid entries
//     empty, full     occupancy decodes
//     nest_ok         ~full, used to mask further interrupts
//     overflow        sticky: push while full
//     underflow       sticky: pop while empty
//
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module epc_stack
  import cpu_pkg::*;
#(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int DEPTH   = 4,
  parameter int CAUSE_W = cpu_pkg::CAUSE_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               push,
  input  logic [XLEN-1:0]    push_pc,
  input  logic [CAUSE_W-1:0] push_cause,
  input  logic               pop,
  input  logic               clr_err,
  output logic [XLEN-1:0]    top_pc,
  output logic [CAUSE_W-1:0] top_cause,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full,
  output logic               nest_ok,
  output logic               overflow,
  output logic               underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [XLEN-1:0]    pc_mem    [DEPTH];
  logic [CAUSE_W-1:0] cause_mem [DEPTH];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             ovf_set;
  logic             unf_set;
  logic             chain;

  // Occupancy decodes from registered count only.
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign nest_ok = ~full;

  // A simultaneous push+pop on a non-empty stack replaces the top in place;
  // on an empty stack it degenerates to a plain push into entry 0.
  assign chain   = push & pop & ~empty;
  assign wr_en   = push & (~full | pop);
  assign wr_idx  = chain ? IDX_W'(count - ONE_C) : IDX_W'(count);
  assign cnt_inc = push & ~full & ~chain;
  assign cnt_dec = pop & ~push & ~empty;
  assign ovf_set = push & ~pop & full;
  assign unf_set = pop & ~push & empty;

  assign top_idx   = IDX_W'(count - ONE_C);
  assign top_pc    = empty ? '0 : pc_mem[top_idx];
  assign top_cause = empty ? '0 : cause_mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        cause_mem[i] <= '0;
      end
    end else if (en) begin
      if (wr_en) begin
        pc_mem[wr_idx]    <= push_pc;
        cause_mem[wr_idx] <= push_cause;
      end
      if (cnt_inc)
        count <= count + ONE_C;
      else if (cnt_dec)
        count <= count - ONE_C;
      // Set takes priority over a same-cycle clear.
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule

`default_nettype wire
